// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared types and constants for the data-memory responder.
//   - dmem_rsp_state_t : request/response FSM states
//   - BE_W             : number of byte enables on a 32-bit word
//   - LATENCY_CNT_W    : width of the wait-state counter (LATENCY 0..15)
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int BE_W          = 4;
  localparam int LATENCY_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_rsp_state_t;

endpackage : dmem_responder_pkg

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   DEPTH x WIDTH word storage with a byte-enabled synchronous write port and
//   a combinational read port sharing one word address.
//   Ports:
//     clk      : clock, rising edge
//     i_we     : write strobe (already qualified by the caller)
//     i_addr   : word index for both read and write
//     i_wdata  : write data
//     i_be     : byte enables, bit i covers bits [8i+7:8i]
//     o_rdata  : combinational read data at i_addr
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [BE_W-1:0]  i_be,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset branch on purpose; contents survive reset and
  // a resettable array would turn into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder end of the CPU data-memory interface. Accepts one load/store at
//   a time on a valid/ready request channel, waits LATENCY cycles, performs the
//   access and holds the result on a valid/ready response channel.
//
//   Parameters:
//     WIDTH   : data/address width (32)
//     DEPTH   : number of 32-bit words (power of two, >= 4)
//     LATENCY : wait cycles between acceptance and response (0..15)
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-low reset
//     req_valid  : request present          req_ready : can accept
//     req_we     : 1 = store, 0 = load       req_addr  : byte address
//     req_wdata  : store data                req_be    : store byte enables
//     rsp_valid  : response present          rsp_ready : requester accepts
//     rsp_rdata  : load data (0 for stores and faults)
//     rsp_err    : access fault
//
//   Build option:
//     DMEM_RSP_MISALIGN_CHECK_EN - when defined, addr[1:0] != 0 faults;
//     otherwise the low address bits are ignored.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [BE_W-1:0]  req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int                       AW  = $clog2(DEPTH);
  localparam logic [LATENCY_CNT_W-1:0] LAT = LATENCY_CNT_W'(LATENCY);

  dmem_rsp_state_t          r_state;
  dmem_rsp_state_t          w_next_state;
  logic [LATENCY_CNT_W-1:0] r_cnt;

  logic                     r_we;
  logic [WIDTH-1:0]         r_addr;
  logic [WIDTH-1:0]         r_wdata;
  logic [BE_W-1:0]          r_be;
  logic [WIDTH-1:0]         r_rdata;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_commit;
  logic                     w_cur_we;
  logic [WIDTH-1:0]         w_cur_addr;
  logic [WIDTH-1:0]         w_cur_wdata;
  logic [BE_W-1:0]          w_cur_be;
  logic                     w_out_of_range;
  logic                     w_misalign;
  logic                     w_fault;
  logic [AW-1:0]            w_word;
  logic [WIDTH-1:0]         w_mem_rdata;
  logic                     w_mem_we;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments for every clocked register so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = (LAT == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == LATENCY_CNT_W'(1)) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && req_valid;

  // The access happens on the edge that enters RESP. With LATENCY = 0 that is
  // the acceptance edge itself, so the request fields come straight from the
  // ports; otherwise they come from the latched copy.
  assign w_commit    = (w_next_state == RESP) && (r_state != RESP) && rst;
  assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_cur_be    = (r_state == IDLE) ? req_be    : r_be;

  // ---------------------------------------------------------------------------
  // Address decode and fault detection
  // ---------------------------------------------------------------------------
  // Any set bit above the word index means the byte address is >= 4*DEPTH.
  assign w_out_of_range = |w_cur_addr[WIDTH-1:AW+2];
  assign w_word         = w_cur_addr[AW+1:2];

`ifdef DMEM_RSP_MISALIGN_CHECK_EN
  assign w_misalign = |w_cur_addr[1:0];
`else
  // Low address bits select a byte within the word and are not needed here.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^w_cur_addr[1:0];
  assign w_misalign        = 1'b0;
`endif

  assign w_fault  = w_out_of_range || w_misalign;
  assign w_mem_we = w_commit && w_cur_we && !w_fault;

  // ---------------------------------------------------------------------------
  // Request latch, wait counter and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= LAT;
      end else if (r_state == WAIT) begin
        r_cnt   <= r_cnt - LATENCY_CNT_W'(1);
      end

      // Response payload is captured once and held for the whole RESP state.
      if (w_commit) begin
        r_err   <= w_fault;
        r_rdata <= (w_cur_we || w_fault) ? '0 : w_mem_rdata;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_word),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_mem_rdata)
  );

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Randomised scoreboard bench for dmem_responder (LATENCY = 2), plus a short
//   directed sequence on a second instance built with LATENCY = 0.
//   The reference model is a plain word array updated by the spec's rules.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH    = 256;
  localparam int LAT_MAIN = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        l0_req_valid;
  logic        l0_req_ready;
  logic        l0_req_we;
  logic [31:0] l0_req_addr;
  logic [31:0] l0_req_wdata;
  logic [3:0]  l0_req_be;
  logic        l0_rsp_valid;
  logic        l0_rsp_ready;
  logic [31:0] l0_rsp_rdata;
  logic        l0_rsp_err;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          cyc       = 0;
  int          bp_mode   = 2;  // 0 random rsp_ready, 1 hold low, 2 hold high

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];

  dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT_MAIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(0)) dut_l0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (l0_req_valid),
    .req_ready (l0_req_ready),
    .req_we    (l0_req_we),
    .req_addr  (l0_req_addr),
    .req_wdata (l0_req_wdata),
    .req_be    (l0_req_be),
    .rsp_valid (l0_rsp_valid),
    .rsp_ready (l0_rsp_ready),
    .rsp_rdata (l0_rsp_rdata),
    .rsp_err   (l0_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1:       rsp_ready = 1'b0;
      2:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (ok === 1'b1) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: applies one access to the word array and returns the
  // response the spec requires.
  task automatic model_apply(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] rd, output logic er);
    int unsigned idx;
    bit          misal;
    misal = 1'b0;
`ifdef DMEM_RSP_MISALIGN_CHECK_EN
    misal = (addr % 4) != 0;
`endif
    er = (addr >= 32'(4 * DEPTH)) || misal;
    rd = 32'd0;
    if (!er) begin
      idx = addr / 4;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = model_mem[idx];
      end
    end
  endtask

  task automatic scramble_req();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom();
    req_wdata = $urandom();
    req_be    = 4'($urandom());
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", req_ready === 1'b1, {31'd0, req_ready}, 32'd1);
      scramble_req();
      return;
    end
    model_apply(we, addr, wdata, be, e.rdata, e.err);
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    scramble_req();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size() == 0 && !rsp_valid, 32'(sb_q.size()), 32'd0);
  endtask

  // Accept a store, then assert reset dly negedges later (1: during WAIT,
  // 2: on the RESP-entry edge). The model is left untouched.
  task automatic reset_midflight(input int dly);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_ready", req_ready === 1'b1, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    scramble_req();
    repeat (dly) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready === 1'b1, {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", rsp_valid === 1'b0, {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard for the LATENCY = 2 instance
  // ---------------------------------------------------------------------------
  logic        mon_prev_valid = 1'b0;
  logic        mon_prev_hs    = 1'b0;
  logic [31:0] mon_prev_rdata = 32'd0;
  logic        mon_prev_err   = 1'b0;
  exp_t        mon_cur;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_prev_valid = 1'b0;
      mon_prev_hs    = 1'b0;
    end else begin
      if (mon_prev_hs) begin
        check("rsp_release", {rsp_valid, req_ready} === 2'b01,
              {30'd0, rsp_valid, req_ready}, 32'd1);
      end
      if (rsp_valid === 1'b1) begin
        if (!mon_prev_valid) begin
          check("rsp_expected", sb_q.size() != 0, rsp_rdata, 32'd0);
          if (sb_q.size() != 0) begin
            mon_cur = sb_q.pop_front();
            check("rsp_latency", cyc == mon_cur.acc_cyc + LAT_MAIN + 1,
                  32'(cyc - mon_cur.acc_cyc), 32'(LAT_MAIN + 1));
            check("rsp_rdata", rsp_rdata === mon_cur.rdata, rsp_rdata, mon_cur.rdata);
            check("rsp_err", rsp_err === mon_cur.err, {31'd0, rsp_err}, {31'd0, mon_cur.err});
          end
        end else begin
          check("rsp_rdata_stable", rsp_rdata === mon_prev_rdata, rsp_rdata, mon_prev_rdata);
          check("rsp_err_stable", rsp_err === mon_prev_err, {31'd0, rsp_err}, {31'd0, mon_prev_err});
        end
        check("req_ready_in_resp", req_ready === 1'b0, {31'd0, req_ready}, 32'd0);
      end
      mon_prev_valid = (rsp_valid === 1'b1) && !rsp_ready;
      mon_prev_hs    = (rsp_valid === 1'b1) && rsp_ready;
      mon_prev_rdata = rsp_rdata;
      mon_prev_err   = rsp_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          n;
    logic        we;
    logic [31:0] addr;

    rst          = 1'b0;
    rsp_ready    = 1'b0;
    scramble_req();
    l0_req_valid = 1'b0;
    l0_req_we    = 1'b0;
    l0_req_addr  = 32'd0;
    l0_req_wdata = 32'd0;
    l0_req_be    = 4'd0;
    l0_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready === 1'b1, {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", rsp_valid === 1'b0, {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata === 32'd0, rsp_rdata, 32'd0);
    check("reset_rsp_err", rsp_err === 1'b0, {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;

    // LATENCY = 0 instance: store, then back-to-back loads with rsp_ready high.
    @(negedge clk);
    l0_req_valid = 1'b1;
    l0_req_we    = 1'b1;
    l0_req_addr  = 32'h10;
    l0_req_wdata = 32'hDEAD_BEEF;
    l0_req_be    = 4'hF;
    check("l0_ready_idle", l0_req_ready === 1'b1, {31'd0, l0_req_ready}, 32'd1);
    @(negedge clk);
    check("l0_store_valid_t1", l0_rsp_valid === 1'b1, {31'd0, l0_rsp_valid}, 32'd1);
    check("l0_store_rdata", l0_rsp_rdata === 32'd0, l0_rsp_rdata, 32'd0);
    check("l0_ready_in_resp", l0_req_ready === 1'b0, {31'd0, l0_req_ready}, 32'd0);
    l0_req_we = 1'b0;
    @(negedge clk);
    check("l0_accept_t2", l0_req_ready === 1'b1, {31'd0, l0_req_ready}, 32'd1);
    @(negedge clk);
    check("l0_load_valid", l0_rsp_valid === 1'b1, {31'd0, l0_rsp_valid}, 32'd1);
    check("l0_load_rdata", l0_rsp_rdata === 32'hDEAD_BEEF, l0_rsp_rdata, 32'hDEAD_BEEF);
    check("l0_load_err", l0_rsp_err === 1'b0, {31'd0, l0_rsp_err}, 32'd0);
    l0_req_addr = 32'h400;
    @(negedge clk);
    check("l0_accept_again", l0_req_ready === 1'b1, {31'd0, l0_req_ready}, 32'd1);
    @(negedge clk);
    check("l0_oor_err", l0_rsp_err === 1'b1, {31'd0, l0_rsp_err}, 32'd1);
    check("l0_oor_rdata", l0_rsp_rdata === 32'd0, l0_rsp_rdata, 32'd0);
    l0_req_valid = 1'b0;

    // Give every word a known value so all later loads are predictable.
    bp_mode = 2;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(4 * i), $urandom(), 4'hF);

    // Directed cases from the test plan.
    bp_mode = 0;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b1, 32'h20, 32'h1122_3344, 4'hF);
    issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5);
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    issue(1'b0, 32'h400, 32'h0, 4'hF);
    issue(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b1, 32'h22, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    drain();

    // Backpressure: response held for six cycles, then released.
    bp_mode = 1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_valid_held", rsp_valid === 1'b1, {31'd0, rsp_valid}, 32'd1);
      check("bp_req_ready_low", req_ready === 1'b0, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    bp_mode = 2;
    drain();

    // Randomised traffic, including misaligned and out-of-range addresses.
    bp_mode = 0;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr = $urandom_range(4 * DEPTH, 32'h0000_FFFF);
      else                           addr = $urandom_range(0, 4 * DEPTH - 1);
      issue(we, addr, $urandom(), 4'($urandom()));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset during WAIT and on the RESP-entry edge; word 0x30 must keep its
    // prior contents in both cases.
    reset_midflight(1);
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    drain();
    reset_midflight(2);
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_dmem_responder
